// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed digit scanner feeding a 4-bit to 7-segment
// decoder. Each digit owns a slot of PRESCALE cycles. The first BLANK_CYCLES
// of every slot drive no digit, which stops ghosting while the common lines
// switch. New digit values are staged and only copied into the displayed
// (shadow) copy at the end of a frame, so a frame never shows a mix of old
// and new values. Leading zeros can be suppressed.

// Per-digit storage: staging register, displayed copy, and this digit's
// link in the leading-zero chain.
module seg_scan_digit #(
    parameter bit IS_LSD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       commit_direct,
    input  logic       commit_stage,
    input  logic [3:0] din,
    input  logic       din_dp,
    input  logic       zero_in,
    input  logic       lz_en,
    output logic [3:0] code,
    output logic       dp,
    output logic       zero_out,
    output logic       suppress
);
    logic [3:0] stage;
    logic       stage_dp;

    // Staging register: the latest load always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage    <= '0;
            stage_dp <= 1'b0;
        end else if (load) begin
            stage    <= din;
            stage_dp <= din_dp;
        end
    end

    // Displayed copy: changes only at the edge closing a frame. A load in
    // that very cycle bypasses staging so it is shown with no frame of lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code <= '0;
            dp   <= 1'b0;
        end else if (commit_direct) begin
            code <= din;
            dp   <= din_dp;
        end else if (commit_stage) begin
            code <= stage;
            dp   <= stage_dp;
        end
    end

    // zero_out: this digit and every digit above it are 4'h0. Codes A-F are
    // nonzero. The rightmost digit is never suppressed so a value of zero
    // still shows a single 0.
    always_comb begin
        zero_out = zero_in && (code == 4'h0);
        suppress = lz_en && zero_out && !IS_LSD;
    end
endmodule

// Top level: slot counter, slot index, pending flag and output decode.
module seg_scan_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_blank,
    output logic [3:0]              nibble_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    dp_out,
    output logic                    blank_out,
    output logic                    frame_done
);
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]             cnt;
    logic [IDX_W-1:0]             idx;
    logic                         pend;
    logic                         lz_q;
    logic                         slot_end;
    logic                         commit_direct;
    logic                         commit_stage;

    logic [NUM_DIGITS-1:0][3:0]   din_bus;
    logic [NUM_DIGITS-1:0][3:0]   shadow;
    logic [NUM_DIGITS-1:0]        shadow_dp;
    logic [NUM_DIGITS-1:0]        suppress;
    logic [NUM_DIGITS:0]          zero_chain;

    logic                         show;
    logic [NUM_DIGITS-1:0]        active;

    assign din_bus  = digits_in;
    assign slot_end = (cnt == CNT_LAST);

    // Slot cycle counter and slot index; a frame is NUM_DIGITS slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending flag: set by a load, cleared whenever a frame boundary
    // commits, whether from the stage or straight from the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else if (frame_done) begin
            pend <= 1'b0;
        end else if (load) begin
            pend <= 1'b1;
        end
    end

    // Suppression enable is registered so no input reaches an output
    // combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lz_q <= 1'b0;
        else        lz_q <= lz_blank;
    end

    assign commit_direct = frame_done && load;
    assign commit_stage  = frame_done && !load && pend;

    // The leading-zero chain runs from the most significant digit downwards.
    assign zero_chain[NUM_DIGITS] = 1'b1;

    genvar k;
    generate
        for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
            seg_scan_digit #(
                .IS_LSD (k == 0)
            ) u_digit (
                .clk           (clk),
                .rst_n         (rst_n),
                .load          (load),
                .commit_direct (commit_direct),
                .commit_stage  (commit_stage),
                .din           (din_bus[k]),
                .din_dp        (dp_in[k]),
                .zero_in       (zero_chain[k+1]),
                .lz_en         (lz_q),
                .code          (shadow[k]),
                .dp            (shadow_dp[k]),
                .zero_out      (zero_chain[k]),
                .suppress      (suppress[k])
            );
        end
    endgenerate

    // Output decode: a suppressed digit looks exactly like the blank phase,
    // but nibble_out always carries the current code.
    always_comb begin
        show       = (cnt >= CNT_BLANK) && !suppress[idx];
        active     = show ? (NUM_DIGITS'(1) << idx) : '0;
        dig_sel    = DIG_ACTIVE_LOW ? ~active : active;
        nibble_out = shadow[idx];
        dp_out     = show && shadow_dp[idx];
        blank_out  = !show;
        frame_done = slot_end && (idx == IDX_LAST);
    end
endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux (4 digits, 8-cycle slots, 2 blank cycles,
// active-low selects). Outputs are sampled on the falling edge; inputs are
// also changed there so they are stable for the next rising edge.
module tb_seg_scan_mux;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_blank;
    logic [3:0]  nibble_out;
    logic [3:0]  dig_sel;
    logic        dp_out;
    logic        blank_out;
    logic        frame_done;

    int n_assert = 0;
    int n_fail   = 0;

    seg_scan_mux #(
        .NUM_DIGITS     (4),
        .PRESCALE       (8),
        .BLANK_CYCLES   (2),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .lz_blank   (lz_blank),
        .nibble_out (nibble_out),
        .dig_sel    (dig_sel),
        .dp_out     (dp_out),
        .blank_out  (blank_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " sel"},   16'(dig_sel),    16'hF);
        check({tag, " blank"}, 16'(blank_out),  16'h1);
        check({tag, " nib"},   16'(nibble_out), 16'h0);
        check({tag, " dp"},    16'(dp_out),     16'h0);
        check({tag, " fd"},    16'(frame_done), 16'h0);
    endtask

    // Checks ncyc cycles of a frame starting at slot 0 / cnt 0. shv/dpv are
    // the displayed values, en_mask the hand-worked set of digits that light
    // (after leading-zero suppression). Optional loads at cycles l1c / l2c.
    task automatic run_frame(input string tag, input logic [15:0] shv, input logic [3:0] dpv,
                             input logic [3:0] en_mask, input int ncyc,
                             input int l1c, input logic [15:0] l1v, input logic [3:0] l1dp,
                             input int l2c, input logic [15:0] l2v);
        for (int c = 0; c < ncyc; c++) begin
            int         slot;
            int         cn;
            logic       en;
            logic [3:0] sel_exp;
            slot    = c / 8;
            cn      = c % 8;
            en      = (cn >= 2) && en_mask[slot];
            sel_exp = en ? ~(4'b0001 << slot) : 4'b1111;
            check($sformatf("%s c%0d sel", tag, c),   16'(dig_sel),    16'(sel_exp));
            check($sformatf("%s c%0d nib", tag, c),   16'(nibble_out), 16'(shv[slot*4 +: 4]));
            check($sformatf("%s c%0d dp", tag, c),    16'(dp_out),     16'(en && dpv[slot]));
            check($sformatf("%s c%0d blank", tag, c), 16'(blank_out),  16'(!en));
            check($sformatf("%s c%0d fd", tag, c),    16'(frame_done), 16'(c == 31));
            if (c == l1c) begin
                load = 1'b1; digits_in = l1v; dp_in = l1dp;
            end else if (c == l2c) begin
                load = 1'b1; digits_in = l2v; dp_in = 4'b0000;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int fd_cnt;
        rst_n     = 1'b0;
        load      = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        lz_blank  = 1'b0;

        // Reset state, then release on a falling edge: that cycle is cycle 0.
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;

        // Frame 0: all zeros, no suppression; load 1234 / dp0 in cycle 5 is
        // held back until the frame boundary.
        run_frame("f0", 16'h0000, 4'b0000, 4'b1111, 32, 5, 16'h1234, 4'b0001, -1, 16'h0);
        lz_blank = 1'b1;
        // Frame 1: 1234 with dp on digit 0; stage 0050 for the next frame.
        run_frame("f1", 16'h1234, 4'b0001, 4'b1111, 32, 10, 16'h0050, 4'b0000, -1, 16'h0);
        // Frame 2: 0050 suppresses digits 3 and 2.
        run_frame("f2", 16'h0050, 4'b0000, 4'b0011, 32, 4, 16'h0000, 4'b0000, -1, 16'h0);
        // Frame 3: all zero, only digit 0 lights.
        run_frame("f3", 16'h0000, 4'b0000, 4'b0001, 32, 4, 16'hA000, 4'b0000, -1, 16'h0);
        // Frame 4: A000 counts as nonzero at the top; two loads, last wins.
        run_frame("f4", 16'hA000, 4'b0000, 4'b1111, 32, 3, 16'h1111, 4'b0000, 20, 16'h2222);
        // Frame 5: 2222; a load coincident with frame_done.
        run_frame("f5", 16'h2222, 4'b0000, 4'b1111, 32, 31, 16'h3333, 4'b0000, -1, 16'h0);
        // Frame 6: 3333 from the first cycle; a pending 4444 then reset in slot 2.
        run_frame("f6", 16'h3333, 4'b0000, 4'b1111, 20, 3, 16'h4444, 4'b1111, -1, 16'h0);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1 check_reset("async_rst");
        lz_blank = 1'b0;
        @(negedge clk);
        check_reset("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // 100 cycles from restart: frame_done at 31/63/95 only, slots in order,
        // the discarded 4444 never appears.
        fd_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            int         slot;
            logic [3:0] sel_exp;
            slot    = (c / 8) % 4;
            sel_exp = ((c % 8) >= 2) ? ~(4'b0001 << slot) : 4'b1111;
            check($sformatf("run c%0d sel", c), 16'(dig_sel),    16'(sel_exp));
            check($sformatf("run c%0d nib", c), 16'(nibble_out), 16'h0);
            check($sformatf("run c%0d fd", c),  16'(frame_done), 16'((c % 32) == 31));
            if (frame_done) fd_cnt++;
            @(negedge clk);
        end
        check("run fd count", 16'(fd_cnt), 16'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexed digit scanner that sits directly upstream of the 4-bit to 7-segment decoder.
- Holds NUM_DIGITS 4-bit digit codes and presents one digit at a time on nibble_out, which drives the decoder's `a` input.
- Drives the matching common-digit select for that digit.
- Provides a tear-free frame-boundary update, an anti-ghosting blank interval and leading-zero suppression.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (>=2).
- PRESCALE, 1000, clock cycles per digit slot (>=2).
- BLANK_CYCLES, 2, cycles at the start of each slot with all digits off (0 <= BLANK_CYCLES < PRESCALE).
- DIG_ACTIVE_LOW, 1, 1 means dig_sel bits are active-low; 0 means active-high.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- digits_in  in  4*NUM_DIGITS  digit codes; digit k occupies bits [4k+3:4k]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal-point request per digit.
- load  in  1  one-cycle strobe that stages digits_in and dp_in.
- lz_blank  in  1  leading-zero suppression enable (level).
- nibble_out  out  4  code of the current digit, to the decoder's `a` input.
- dig_sel  out  NUM_DIGITS  one-hot digit enable, polarity per DIG_ACTIVE_LOW.
- dp_out  out  1  decimal point for the current digit.
- blank_out  out  1  1 whenever no digit is enabled.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- State registers:
  - cnt: slot cycle counter, width clog2(PRESCALE).
  - idx: slot index, width clog2(NUM_DIGITS).
  - stage/stage_dp/pend: staging registers and pending flag.
  - shadow/shadow_dp: displayed digits and decimal points.
- All outputs are combinational decodes of these registers only. There is no path from any input to any output.
- Reset (rst_n=0, asynchronous, no clock needed):
  - cnt=0, idx=0, pend=0, stage=0, shadow=0, dp registers=0.
  - Outputs immediately: dig_sel all inactive (all 1s when DIG_ACTIVE_LOW=1), nibble_out=0, dp_out=0, blank_out=1, frame_done=0.
- Counting:
  - cnt increments every cycle.
  - At cnt==PRESCALE-1, cnt wraps to 0 and idx advances.
  - idx wraps from NUM_DIGITS-1 to 0.
  - A frame is NUM_DIGITS*PRESCALE cycles.
- Phases:
  - BLANK when cnt < BLANK_CYCLES: dig_sel all inactive, blank_out=1, dp_out=0.
  - SHOW otherwise: dig_sel has only bit idx active, blank_out=0, dp_out=shadow_dp[idx].
  - Exception in SHOW: if the digit is suppressed, it behaves as BLANK.
- nibble_out = shadow digit[idx] in both phases. Suppressed digits still output their code.
- Leading-zero suppression, when lz_blank=1:
  - Digit k>0 is suppressed if it and every digit above it equal 4'h0.
  - Digit 0 is never suppressed.
  - Evaluated on shadow every cycle.
  - Codes 4'hA-4'hF count as nonzero.
- frame_done = 1 exactly when idx==NUM_DIGITS-1 and cnt==PRESCALE-1.
- Update path:
  - load=1 writes digits_in/dp_in to stage and sets pend.
  - A repeat load overwrites stage; the latest load wins.
  - On the clock edge ending a frame_done cycle: if load=1 in that cycle, shadow takes digits_in/dp_in directly and pend clears. Otherwise, if pend=1, shadow takes stage and pend clears.
  - shadow never changes at any other time.
- Reset mid-frame aborts the frame and discards any pending load. After release, scanning restarts at slot 0, cnt 0.

Test Plan (all scenarios: NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, DIG_ACTIVE_LOW=1):
1. Hold reset, then release with lz_blank=0 and no load.
   - During reset: dig_sel=4'b1111, blank_out=1, nibble_out=0, frame_done=0.
   - After release: cycles 0-1 give dig_sel=1111; cycles 2-7 give dig_sel=1110, nibble_out=0; cycles 10-15 give dig_sel=1101.
2. Load digits_in=16'h1234, dp_in=4'b0001 in cycle 5.
   - Outputs are unchanged until the frame_done edge (cycle 31).
   - Next frame: slots 0..3 show 4,3,2,1; dp_out=1 only in slot-0 SHOW cycles.
3. Set lz_blank=1 with shadow=16'h0050.
   - Slots 3 and 2: dig_sel=1111, blank_out=1 for all 8 cycles.
   - Slot 1 shows 5; slot 0 shows 0.
   - With shadow=16'h0000, only slot 0 enables.
   - With shadow=16'hA000, all four digits enable.
4. Issue load 16'h1111 at cycle 3 and load 16'h2222 at cycle 20.
   - Next frame shows 2222.
   - A separate load of 16'h3333 coincident with frame_done shows 3333 from the very next cycle.
5. Assert rst_n=0 asynchronously mid-slot 2 with a pending load.
   - Outputs take reset values with no clock edge.
   - After release: slot 0, shadow=0; the pending value is never displayed.
6. Run 100 cycles.
   - frame_done is high exactly in cycles 31, 63 and 95, for one cycle each.
   - Every idx value is visited once per frame in ascending order.
